// File: rtl/wishbone_sdram_arbiter.sv
// wishbone_sdram_arbiter: cyc-locked round-robin 2:1 Wishbone arbiter with stall watchdog; ports m0_*/m1_* masters, s_* SDRAM slave, grant one-hot owner
module wishbone_sdram_arbiter #(
  parameter int ADDR_WIDTH     = 30,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_data_write,
  input  logic [DATA_WIDTH/8-1:0] m0_sel,
  input  logic                    m0_cyc,
  input  logic                    m0_stb,
  input  logic                    m0_we,
  input  logic [2:0]              m0_cti,
  input  logic [1:0]              m0_bte,
  output logic [DATA_WIDTH-1:0]   m0_data_read,
  output logic                    m0_ack,
  output logic                    m0_err,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_data_write,
  input  logic [DATA_WIDTH/8-1:0] m1_sel,
  input  logic                    m1_cyc,
  input  logic                    m1_stb,
  input  logic                    m1_we,
  input  logic [2:0]              m1_cti,
  input  logic [1:0]              m1_bte,
  output logic [DATA_WIDTH-1:0]   m1_data_read,
  output logic                    m1_ack,
  output logic                    m1_err,
  output logic [ADDR_WIDTH-1:0]   s_addr,
  output logic [DATA_WIDTH-1:0]   s_data_write,
  output logic [DATA_WIDTH/8-1:0] s_sel,
  output logic                    s_cyc,
  output logic                    s_stb,
  output logic                    s_we,
  output logic [2:0]              s_cti,
  output logic [1:0]              s_bte,
  input  logic                    s_ack,
  input  logic                    s_err,
  input  logic [DATA_WIDTH-1:0]   s_data_read,
  output logic [1:0]              grant
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1, ABORT} state_t;
  state_t state, state_n;
  logic last_owner;
  logic [CW-1:0] cnt;
  logic own0, own1, own, m_cyc, m_stb, timeout;
  always_comb begin
    own0 = state == OWN0 && !reset;
    own1 = state == OWN1 && !reset;
    own = own0 | own1;
    m_cyc = own1 ? m1_cyc : m0_cyc;
    m_stb = own1 ? m1_stb : m0_stb;
    timeout = own && cnt == CW'(TIMEOUT_CYCLES) && !s_ack && !s_err;
    s_cyc = own & m_cyc & !timeout;
    s_stb = own & m_cyc & m_stb & !timeout;
    s_we = own & (own1 ? m1_we : m0_we);
    s_addr = own0 ? m0_addr : own1 ? m1_addr : '0;
    s_data_write = own0 ? m0_data_write : own1 ? m1_data_write : '0;
    s_sel = own0 ? m0_sel : own1 ? m1_sel : '0;
    s_cti = own0 ? m0_cti : own1 ? m1_cti : '0;
    s_bte = own0 ? m0_bte : own1 ? m1_bte : '0;
    m0_data_read = s_data_read;
    m1_data_read = s_data_read;
    m0_ack = own0 & s_ack;
    m1_ack = own1 & s_ack;
    m0_err = own0 & (s_err | timeout);
    m1_err = own1 & (s_err | timeout);
    grant = {own1, own0};
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (m0_cyc && (!m1_cyc || last_owner)) ? OWN0 : m1_cyc ? OWN1 : IDLE;
      OWN0,
      OWN1:    state_n = timeout ? ABORT : !m_cyc ? IDLE : state;
      default: state_n = (last_owner ? m1_cyc : m0_cyc) ? ABORT : IDLE;
    endcase
  end
  // last_owner tracks the owner every OWN cycle, so in ABORT it names the aborted master
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= IDLE;
      last_owner <= 1'b1;
      cnt <= '0;
    end else begin
      state <= state_n;
      if (own) last_owner <= own1;
      cnt <= (!own || s_ack || s_err || state_n != state) ? '0 :
             (s_stb && cnt != CW'(TIMEOUT_CYCLES)) ? cnt + 1'b1 : cnt;
    end
  end
endmodule

// File: tb/tb_wishbone_sdram_arbiter.sv
// tb_wishbone_sdram_arbiter: directed self-checking bench for the two-master SDRAM arbiter
module tb_wishbone_sdram_arbiter;
  logic clk_sys = 1'b0;
  logic reset;
  logic [29:0] m0_addr, m1_addr, s_addr;
  logic [31:0] m0_data_write, m1_data_write, s_data_write;
  logic [31:0] m0_data_read, m1_data_read, s_data_read;
  logic [3:0] m0_sel, m1_sel, s_sel;
  logic m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [2:0] m0_cti, m1_cti, s_cti;
  logic [1:0] m0_bte, m1_bte, s_bte;
  logic m0_ack, m0_err, m1_ack, m1_err;
  logic s_cyc, s_stb, s_we, s_ack, s_err;
  logic [1:0] grant;
  int tests = 0;
  int fails = 0;
  always #5 clk_sys = ~clk_sys;
  wishbone_sdram_arbiter #(.ADDR_WIDTH(30), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .m0_addr(m0_addr), .m0_data_write(m0_data_write), .m0_sel(m0_sel), .m0_cyc(m0_cyc),
    .m0_stb(m0_stb), .m0_we(m0_we), .m0_cti(m0_cti), .m0_bte(m0_bte),
    .m0_data_read(m0_data_read), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_addr(m1_addr), .m1_data_write(m1_data_write), .m1_sel(m1_sel), .m1_cyc(m1_cyc),
    .m1_stb(m1_stb), .m1_we(m1_we), .m1_cti(m1_cti), .m1_bte(m1_bte),
    .m1_data_read(m1_data_read), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_addr(s_addr), .s_data_write(s_data_write), .s_sel(s_sel), .s_cyc(s_cyc),
    .s_stb(s_stb), .s_we(s_we), .s_cti(s_cti), .s_bte(s_bte),
    .s_ack(s_ack), .s_err(s_err), .s_data_read(s_data_read), .grant(grant)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask
  task automatic settle;
    #1;
  endtask
  initial begin
    reset = 1'b1;
    {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_ack, s_err} = '0;
    m0_addr = 30'h100; m0_data_write = 32'hDEADBEEF; m0_sel = 4'hF; m0_cti = 3'd0; m0_bte = 2'd0;
    m1_addr = 30'h200; m1_data_write = 32'h12345678; m1_sel = 4'h3; m1_cti = 3'd0; m1_bte = 2'd1;
    s_data_read = 32'hCAFEF00D;
    tick; tick; settle;
    chk("rst_grant", grant, 2'b00);
    chk("rst_s_cyc", s_cyc, 1'b0);
    chk("rst_s_addr", s_addr, 30'h0);
    chk("rd_passthru", m1_data_read, 32'hCAFEF00D);
    // single master write
    reset = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1;
    settle;
    chk("t1_latency_cyc", s_cyc, 1'b0);
    chk("t1_latency_grant", grant, 2'b00);
    tick; settle;
    chk("t1_grant", grant, 2'b01);
    chk("t1_addr", s_addr, 30'h100);
    chk("t1_data", s_data_write, 32'hDEADBEEF);
    chk("t1_sel", s_sel, 4'hF);
    chk("t1_we", s_we, 1'b1);
    chk("t1_stb", s_stb, 1'b1);
    tick; tick;
    s_ack = 1'b1;
    settle;
    chk("t1_m0_ack", m0_ack, 1'b1);
    chk("t1_m1_ack", m1_ack, 1'b0);
    tick;
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    settle;
    chk("t1_ack_drop", m0_ack, 1'b0);
    chk("t1_s_cyc_drop", s_cyc, 1'b0);
    tick; settle;
    chk("t1_idle_grant", grant, 2'b00);
    chk("t1_idle_sel", s_sel, 4'h0);
    // tie after reset
    reset = 1'b1;
    tick;
    reset = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    tick; settle;
    chk("t2_first", grant, 2'b01);
    s_ack = 1'b1;
    settle;
    chk("t2_m0_ack", m0_ack, 1'b1);
    chk("t2_m1_ack", m1_ack, 1'b0);
    tick;
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    tick; settle;
    chk("t2_gap", grant, 2'b00);
    m0_cyc = 1'b1; m0_stb = 1'b1;
    tick; settle;
    // round-robin: owner drops cyc for one cycle after each ack, then re-requests
    for (int i = 0; i < 8; i++) begin
      logic e;
      e = (i % 2 == 0);
      chk($sformatf("t3_grant%0d", i), grant, e ? 2'b10 : 2'b01);
      chk($sformatf("t3_addr%0d", i), s_addr, e ? 30'h200 : 30'h100);
      s_ack = 1'b1;
      settle;
      chk($sformatf("t3_ack%0d", i), {m1_ack, m0_ack}, e ? 2'b10 : 2'b01);
      tick;
      s_ack = 1'b0;
      if (e) begin m1_cyc = 1'b0; m1_stb = 1'b0; end
      else begin m0_cyc = 1'b0; m0_stb = 1'b0; end
      tick;
      if (e) begin m1_cyc = 1'b1; m1_stb = 1'b1; end
      else begin m0_cyc = 1'b1; m0_stb = 1'b1; end
      tick; settle;
    end
    // burst lock on m1
    m0_cyc = 1'b0; m0_stb = 1'b0;
    m1_cti = 3'b010;
    for (int b = 0; b < 4; b++) begin
      if (b == 1) begin m0_cyc = 1'b1; m0_stb = 1'b1; end
      if (b == 3) m1_cti = 3'b111;
      s_ack = 1'b1;
      settle;
      chk($sformatf("t4_grant%0d", b), grant, 2'b10);
      chk($sformatf("t4_acks%0d", b), {m1_ack, m0_ack}, 2'b10);
      chk($sformatf("t4_cti%0d", b), s_cti, b == 3 ? 3'b111 : 3'b010);
      tick;
    end
    s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0; m1_cti = 3'd0;
    settle;
    chk("t4_hold", grant, 2'b10);
    tick; settle;
    chk("t4_gap", grant, 2'b00);
    tick; settle;
    chk("t4_m0", grant, 2'b01);
    // watchdog: slave never answers
    m1_cyc = 1'b1; m1_stb = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t5_noerr%0d", k), m0_err, 1'b0);
      chk($sformatf("t5_stb%0d", k), s_stb, 1'b1);
      tick; settle;
    end
    chk("t5_err", m0_err, 1'b1);
    chk("t5_s_cyc", s_cyc, 1'b0);
    chk("t5_s_stb", s_stb, 1'b0);
    chk("t5_m1_err", m1_err, 1'b0);
    tick; settle;
    chk("t5_err_pulse", m0_err, 1'b0);
    chk("t5_abort_grant", grant, 2'b00);
    chk("t5_abort_cyc", s_cyc, 1'b0);
    tick; settle;
    chk("t5_abort_hold", grant, 2'b00);
    m0_cyc = 1'b0; m0_stb = 1'b0;
    tick; settle;
    chk("t5_idle", grant, 2'b00);
    tick; settle;
    chk("t5_m1", grant, 2'b10);
    // reset during m1 read wait
    m0_cyc = 1'b1; m0_stb = 1'b1;
    chk("t6_read", s_we, 1'b0);
    chk("t6_cyc", s_cyc, 1'b1);
    tick; tick;
    reset = 1'b1; s_ack = 1'b1;
    settle;
    chk("t6_rst_cyc", s_cyc, 1'b0);
    chk("t6_rst_grant", grant, 2'b00);
    chk("t6_rst_ack", m1_ack, 1'b0);
    tick;
    reset = 1'b0; s_ack = 1'b0;
    settle;
    chk("t6_post_idle", grant, 2'b00);
    tick; settle;
    chk("t6_tie", grant, 2'b01);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
